// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: queue entry layout and drain-FSM states.
package wb_stage_pkg;

  localparam int ADDR_LINE = 5;
  localparam int D_SIZE    = 32;

  typedef struct packed {
    logic                 wen;
    logic                 is_load;
    logic [ADDR_LINE-1:0] dest;
    logic [D_SIZE-1:0]    result;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of writeback entries; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t      mem_q [DEPTH];
  wb_entry_t      mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: queues execute results, merges load data, drives the register-file write port
// and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_wen,
  input  logic                 ex_is_load,
  input  logic [ADDR_LINE-1:0] ex_dest,
  input  logic [D_SIZE-1:0]    ex_result,
  input  logic                 mem_rdata_valid,
  input  logic [D_SIZE-1:0]    mem_rdata,
  output logic                 w_f_wb,
  output logic [ADDR_LINE-1:0] addr_in_f_wb,
  output logic [D_SIZE-1:0]    write_data_f_wb,
  output logic                 retire,
  output logic [31:0]          retire_count,
  output logic                 proto_err,
  output logic                 state_dbg
);

  wb_state_t            state_q, state_d;
  wb_entry_t            head, push_entry;
  logic                 fifo_full, fifo_empty;
  logic                 accept, pop, stray, w_now;
  logic [D_SIZE-1:0]    ret_data;
  logic                 w_f_wb_q, w_f_wb_d;
  logic [ADDR_LINE-1:0] addr_q, addr_d;
  logic [D_SIZE-1:0]    data_q, data_d;
  logic                 retire_q, retire_d;
  logic [31:0]          retire_count_q, retire_count_d;
  logic                 proto_err_q, proto_err_d;

  // Handshake: a result transfers on a cycle where ex_valid and ex_ready are both high at the
  // clock edge. ex_ready depends only on the registered occupancy, so a pop from a full queue
  // frees the slot one cycle later.
  assign ex_ready   = !fifo_full;
  assign accept     = ex_valid && ex_ready;
  assign push_entry = '{wen: ex_wen, is_load: ex_is_load, dest: ex_dest, result: ex_result};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    ret_data = head.result;
    case (state_q)
      WB_IDLE: begin
        if (!fifo_empty) begin
          if (!head.is_load) begin
            pop = 1'b1;
          end else if (mem_rdata_valid) begin
            pop      = 1'b1;
            ret_data = mem_rdata;
          end else begin
            state_d = WB_WAIT_LOAD;
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (fifo_empty || !head.is_load) begin
          state_d = WB_IDLE;
        end else if (mem_rdata_valid) begin
          pop      = 1'b1;
          ret_data = mem_rdata;
          state_d  = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Load data with no load at the head has nowhere to go; it is dropped and flagged.
  always_comb begin
    stray          = mem_rdata_valid && (fifo_empty || !head.is_load);
    w_now          = pop && head.wen && (head.dest != '0);
    w_f_wb_d       = w_now;
    retire_d       = pop;
    addr_d         = w_now ? head.dest : addr_q;
    data_d         = w_now ? ret_data : data_q;
    retire_count_d = retire_count_q + 32'(pop);
    proto_err_d    = proto_err_q || stray;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WB_IDLE;
      w_f_wb_q       <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      retire_q       <= 1'b0;
      retire_count_q <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_f_wb_q       <= w_f_wb_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      retire_q       <= retire_d;
      retire_count_q <= retire_count_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign w_f_wb          = w_f_wb_q;
  assign addr_in_f_wb    = addr_q;
  assign write_data_f_wb = data_q;
  assign retire          = retire_q;
  assign retire_count    = retire_count_q;
  assign proto_err       = proto_err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic, scored against a queue-level model.
`timescale 1ns/1ps
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int EW    = 1 + ADDR_LINE + D_SIZE + 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ex_valid = 1'b0;
  logic                 ex_ready;
  logic                 ex_wen = 1'b0;
  logic                 ex_is_load = 1'b0;
  logic [ADDR_LINE-1:0] ex_dest = '0;
  logic [D_SIZE-1:0]    ex_result = '0;
  logic                 mem_rdata_valid = 1'b0;
  logic [D_SIZE-1:0]    mem_rdata = '0;
  logic                 w_f_wb;
  logic [ADDR_LINE-1:0] addr_in_f_wb;
  logic [D_SIZE-1:0]    write_data_f_wb;
  logic                 retire;
  logic [31:0]          retire_count;
  logic                 proto_err;
  logic                 state_dbg;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_wen          (ex_wen),
    .ex_is_load      (ex_is_load),
    .ex_dest         (ex_dest),
    .ex_result       (ex_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .w_f_wb          (w_f_wb),
    .addr_in_f_wb    (addr_in_f_wb),
    .write_data_f_wb (write_data_f_wb),
    .retire          (retire),
    .retire_count    (retire_count),
    .proto_err       (proto_err),
    .state_dbg       (state_dbg)
  );

  // Reference model: pending instructions as a plain queue, plus architectural output state.
  wb_entry_t            mq[$];
  logic [EW-1:0]        exp_q[$];
  logic                 m_perr = 1'b0;
  logic [ADDR_LINE-1:0] m_addr = '0;
  logic [D_SIZE-1:0]    m_data = '0;
  logic [31:0]          m_cnt = '0;
  int                   n_checks = 0;
  int                   n_fail = 0;
  bit                   mon_en = 1'b0;

  task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    wb_entry_t         e;
    logic              w;
    logic [D_SIZE-1:0] d;
    bit                room;
    if (reset) begin
      mq.delete();
      m_perr = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = '0;
    end else begin
      room = (mq.size() < DEPTH);
      if (mem_rdata_valid && (mq.size() == 0 || !mq[0].is_load)) m_perr = 1'b1;
      if (mq.size() > 0) begin
        e = mq[0];
        if (!e.is_load || mem_rdata_valid) begin
          d = e.is_load ? mem_rdata : e.result;
          w = e.wen && (e.dest != 0);
          m_cnt = m_cnt + 1;
          if (w) begin
            m_addr = e.dest;
            m_data = d;
          end
          exp_q.push_back({w, m_addr, m_data, m_cnt});
          void'(mq.pop_front());
        end
      end
      if (ex_valid && room)
        mq.push_back('{wen: ex_wen, is_load: ex_is_load, dest: ex_dest, result: ex_result});
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en) begin
      check("ex_ready", ex_ready, mq.size() < DEPTH);
      check("proto_err", proto_err, m_perr);
      check("retire_count", retire_count, m_cnt);
      check("addr_hold", addr_in_f_wb, m_addr);
      check("data_hold", write_data_f_wb, m_data);
      check("retire", retire, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("retire_fields", {w_f_wb, addr_in_f_wb, write_data_f_wb, retire_count}, e);
      end else begin
        check("w_f_wb_idle", w_f_wb, 1'b0);
      end
    end
  end

  task automatic set_inputs(bit v, bit wen, bit ld, logic [ADDR_LINE-1:0] dest,
                            logic [D_SIZE-1:0] res, bit mv, logic [D_SIZE-1:0] md);
    ex_valid        = v;
    ex_wen          = wen;
    ex_is_load      = ld;
    ex_dest         = dest;
    ex_result       = res;
    mem_rdata_valid = mv;
    mem_rdata       = md;
  endtask

  task automatic drive(bit v, bit wen, bit ld, logic [ADDR_LINE-1:0] dest,
                       logic [D_SIZE-1:0] res, bit mv, logic [D_SIZE-1:0] md);
    @(negedge clk);
    set_inputs(v, wen, ld, dest, res, mv, md);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single ALU op
    drive(1, 1, 0, 5'd3, 32'hDEADBEEF, 0, '0);
    idle(3);
    check("t1_count", retire_count, 32'd1);
    check("t1_addr", addr_in_f_wb, 5'd3);
    check("t1_data", write_data_f_wb, 32'hDEADBEEF);

    // Back-to-back ALU ops
    for (int i = 1; i <= 4; i++) drive(1, 1, 0, ADDR_LINE'(i), 32'h100 + 32'(i), 0, '0);
    idle(3);
    check("t2_count", retire_count, 32'd5);

    // Load then ALU; load data returns later
    drive(1, 1, 1, 5'd5, 32'hBAD, 0, '0);
    drive(1, 1, 0, 5'd6, 32'h6666, 0, '0);
    @(posedge clk);
    #1 check("t3_full", ex_ready, 1'b0);
    idle(1);
    drive(0, 0, 0, '0, '0, 1, 32'h1234);
    idle(3);
    check("t3_addr", addr_in_f_wb, 5'd6);
    check("t3_data", write_data_f_wb, 32'h6666);

    // Write to r0 retires without writing
    drive(1, 1, 0, 5'd0, 32'hCAFE, 0, '0);
    idle(3);
    check("t4_count", retire_count, 32'd8);
    check("t4_addr", addr_in_f_wb, 5'd6);

    // Stray load data on an empty queue
    drive(0, 0, 0, '0, '0, 1, 32'h55);
    idle(3);
    check("t5_perr", proto_err, 1'b1);

    // Reset while a load waits with the queue full
    drive(1, 1, 1, 5'd7, '0, 0, '0);
    drive(1, 1, 0, 5'd8, 32'h88, 0, '0);
    idle(2);
    do_reset();
    check("t6_w", w_f_wb, 1'b0);
    check("t6_retire", retire, 1'b0);
    check("t6_count", retire_count, 32'd0);
    check("t6_addr", addr_in_f_wb, 5'd0);
    check("t6_data", write_data_f_wb, 32'd0);
    check("t6_ready", ex_ready, 1'b1);
    check("t6_perr0", proto_err, 1'b0);
    drive(0, 0, 0, '0, '0, 1, 32'h77);
    idle(2);
    check("t6_perr1", proto_err, 1'b1);

    // Random traffic; load data only returned when a load is at the head
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit mv;
      @(negedge clk);
      mv = (mq.size() > 0) && mq[0].is_load && ($urandom_range(0, 2) == 0);
      set_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, ADDR_LINE'($urandom_range(0, 31)),
                 $urandom(), mv, $urandom());
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_inputs(1'b0, 1'b0, 1'b0, '0, '0, (mq.size() > 0) && mq[0].is_load, $urandom());
    end
    idle(3);
    check("drain_model", mq.size(), 0);
    check("drain_exp", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
